uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds bytes from NUM_REQ requesters into one uart_tx.
// A burst keeps its owner locked until its last byte or until the owner stalls for HOLD_TIMEOUT clocks.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_BITS    = 8,
  parameter int HOLD_TIMEOUT = 1000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  input  logic [NUM_REQ*2-1:0]           req_parity,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [DATA_BITS-1:0]           tx_data,
  output logic                           tx_valid,
  input  logic                           tx_ready,
  output logic [1:0]                     parity_mode,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           busy,
  output logic                           timeout_err
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(HOLD_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] sel_idx;
  logic [ID_W-1:0] cap_idx;
  logic [ID_W-1:0] next_ptr;
  logic [ID_W:0]   cand;
  logic            sel_found;
  logic            owner_last;
  logic            cap;
  logic [CNT_W-1:0] hold_cnt;

  // First valid requester at or above rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (!sel_found && req_valid[cand[ID_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[ID_W-1:0];
      end
    end
  end

  // Handshakes: a requester byte moves on any edge with req_valid[i] && req_ready[i];
  // req_ready never waits on req_valid being stable beyond that edge. Toward uart_tx,
  // tx_valid/tx_data hold until an edge with tx_valid && tx_ready.
  always_comb begin
    req_ready = '0;
    if (rst_n) begin
      case (state)
        IDLE:    if (sel_found) req_ready[sel_idx] = 1'b1;
        HOLD:    req_ready[grant_id] = req_valid[grant_id];
        default: req_ready = '0;
      endcase
    end
  end

  assign cap      = |(req_valid & req_ready);
  assign cap_idx  = (state == HOLD) ? grant_id : sel_idx;
  assign next_ptr = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      parity_mode <= 2'b00;
      grant_id    <= '0;
      rr_ptr      <= '0;
      owner_last  <= 1'b0;
      hold_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      if (cap) begin
        // Capture wins over a timeout landing on the same edge.
        tx_data     <= req_data[cap_idx*DATA_BITS +: DATA_BITS];
        parity_mode <= req_parity[cap_idx*2 +: 2];
        grant_id    <= cap_idx;
        owner_last  <= req_last[cap_idx];
        tx_valid    <= 1'b1;
        hold_cnt    <= '0;
        state       <= LOAD;
      end else begin
        case (state)
          LOAD: begin
            if (tx_valid && tx_ready) begin
              tx_valid <= 1'b0;
              hold_cnt <= '0;
              if (owner_last) begin
                rr_ptr <= next_ptr;
                state  <= IDLE;
              end else begin
                state  <= HOLD;
              end
            end
          end
          HOLD: begin
            if (hold_cnt == CNT_W'(HOLD_TIMEOUT - 1)) begin
              hold_cnt    <= '0;
              rr_ptr      <= next_ptr;
              timeout_err <= 1'b1;
              state       <= IDLE;
            end else begin
              hold_cnt <= hold_cnt + CNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
